// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Framing errors and FIFO overflow are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 1250,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PtrW:0]   CountMax = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StRecover
    } state_e;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [CntW-1:0] baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            push_q;
    logic            frame_err_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (!rx_sync_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_cnt_q == HalfLast) begin
                        baud_cnt_q <= '0;
                        // A start bit that is high again at mid-bit is treated as a glitch
                        state_q    <= rx_sync_q ? StIdle : StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_cnt_q == BitLast) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_sync_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_cnt_q == BitLast) begin
                        baud_cnt_q <= '0;
                        if (rx_sync_q) begin
                            push_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StRecover;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StRecover: begin
                    // Wait out a break so it yields only the one framing error
                    baud_cnt_q <= '0;
                    if (rx_sync_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            overflow_q;
    logic            full;
    logic            pop;
    logic            wr_en;

    always_comb begin
        full  = (count_q == CountMax);
        pop   = o_valid && i_ready;
        // A pop on the same edge frees the slot the push needs
        wr_en = push_q && (!full || pop);
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q && full && !pop;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        o_valid     = (count_q != '0);
        o_data      = o_valid ? mem_q[rd_ptr_q] : 8'h00;
        o_frame_err = frame_err_q;
        o_overflow  = overflow_q;
    end

endmodule
